tile_scanner: RTL and testbench
===============================

TILE_SCANNER -- requirements
Module: tile_scanner

Interface
REQ-001 Parameter NUM_TILES, default 768: number of map tiles swept per pass; addresses 0..NUM_TILES-1.
REQ-002 Parameter ADDR_W, default 10: tile address width.
REQ-003 Parameter DATA_W, default 4: tile code width.
REQ-004 Parameter PELLET_CODE, default 2: tile code counted as a pellet.
REQ-005 Port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 Port reset  input  1  synchronous reset, active-high.
REQ-007 Port start  input  1  one-cycle request to begin a sweep.
REQ-008 Port ram_req  output  1  request for the shared tile-RAM read port.
REQ-009 Port ram_grant  input  1  port granted this cycle; ram_addr is accepted.
REQ-010 Port ram_addr  output  ADDR_W  tile-RAM read address.
REQ-011 Port ram_rdata  input  DATA_W  tile-RAM read data, valid one cycle after an accepted address.
REQ-012 Port read_addr  output  ADDR_W  tile address presented downstream to check_done.
REQ-013 Port read_data  output  DATA_W  tile code paired with read_addr.
REQ-014 Port tile_valid  output  1  read_addr/read_data pair is valid this cycle.
REQ-015 Port busy  output  1  sweep in progress.
REQ-016 Port sweep_done  output  1  one-cycle pulse when the last tile of a sweep has been emitted.
REQ-017 Port pellet_count  output  ADDR_W  number of PELLET_CODE tiles in the current or last sweep.

Function
REQ-018 The FSM SHALL have states IDLE, SCAN, DRAIN and DONE.
REQ-019 IDLE: start=1 -> SCAN next cycle; the address counter is cleared to 0 and pellet_count is cleared to 0.
REQ-020 start SHALL be ignored in SCAN, DRAIN and DONE.
REQ-021 SCAN: ram_req=1 and ram_addr=counter; the counter increments only in cycles where ram_grant=1.
REQ-022 With ram_grant=0, ram_addr SHALL hold its value; no tile is issued and no tile is skipped.
REQ-023 An address accepted in cycle t SHALL have its ram_rdata captured at the edge ending t+1.
REQ-024 The captured pair SHALL appear on read_addr/read_data with tile_valid=1 in cycle t+2, for exactly one cycle.
REQ-025 Total latency from accepted address to tile_valid SHALL be 2 cycles.
REQ-026 Tiles SHALL be emitted in strictly ascending address order, each exactly once per sweep.
REQ-027 When address NUM_TILES-1 is accepted -> DRAIN; ram_req=0 from the next cycle.
REQ-028 DRAIN: stay until the pair for address NUM_TILES-1 has been emitted, then -> DONE.
REQ-029 DONE lasts one cycle: sweep_done=1, then -> IDLE.
REQ-030 busy=1 in SCAN and DRAIN; busy=0 in IDLE and DONE.
REQ-031 pellet_count SHALL increment by 1 in each cycle where tile_valid=1 and read_data==PELLET_CODE.
REQ-032 pellet_count SHALL be final in the sweep_done cycle and held until the next accepted start; it cannot overflow (NUM_TILES < 2^ADDR_W).
REQ-033 When tile_valid=0, read_addr and read_data SHALL be driven to 0.
REQ-034 With ram_grant toggling, tile_valid gaps SHALL mirror the grant gaps, delayed by 2 cycles.
REQ-035 A start in the same cycle as the DONE cycle SHALL be ignored; a new sweep requires start in IDLE.

Reset
REQ-036 reset=1 at any edge, including mid-sweep, SHALL force IDLE and the following output values: ram_req=0, ram_addr=0, read_addr=0, read_data=0, tile_valid=0, busy=0, sweep_done=0, pellet_count=0.
REQ-037 In-flight RAM data at reset SHALL be discarded and SHALL NOT be emitted after reset releases.

Verification
REQ-038 Full-grant sweep: reset, start pulse, ram_grant held 1, RAM returns 0 everywhere except address 765=2 -> read_addr runs 0..767 on 768 consecutive tile_valid cycles; first tile_valid 3 cycles after start; sweep_done 1 cycle after addr 767 emitted; pellet_count=1.
REQ-039 Stalls: ram_grant=0 for 5 cycles after address 100 is accepted -> ram_addr holds 101; tile_valid shows a 5-cycle gap; no address is skipped or repeated; pellet_count is unchanged versus the full-grant case.
REQ-040 Start while busy: start pulsed mid-sweep and in the DONE cycle -> the sweep continues unchanged; exactly one sweep_done; no restart.
REQ-041 Reset mid-sweep: reset at address 400 -> all outputs are 0 next cycle; after release, no stray tile_valid; a new start sweeps again from 0.
REQ-042 All-pellet map: every tile = PELLET_CODE -> pellet_count=768 at sweep_done and held through 10 idle cycles.
REQ-043 Empty map: no PELLET_CODE tiles -> pellet_count=0 at sweep_done, and the downstream check_done asserts game_over.

Source files
------------

// File: rtl/tile_scanner.sv
// Sweeps tile RAM addresses 0..NUM_TILES-1 through a shared, arbitrated read
// port. Each tile is forwarded downstream as an (address, code) pair two
// cycles after its address is accepted. The pellet tiles seen in the sweep are
// counted as they go by.
//
// RAM handshake: ram_req is the valid and ram_grant is the ready. An address is
// accepted in a cycle where ram_req=1 and ram_grant=1. ram_addr holds steady
// while ram_req=1 and ram_grant=0. ram_rdata for an accepted address is valid
// in the following cycle.
module tile_scanner #(
  parameter int NUM_TILES   = 768,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 4,
  parameter int PELLET_CODE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ram_req,
  input  logic              ram_grant,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              tile_valid,
  output logic              busy,
  output logic              sweep_done,
  output logic [ADDR_W-1:0] pellet_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TILES - 1);
  localparam logic [DATA_W-1:0] PELLET    = DATA_W'(PELLET_CODE);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  // Stage 1: an address accepted last cycle, whose data is on ram_rdata now.
  logic                s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  // Stage 2: the registered downstream pair.
  logic                tv_q, tv_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   pel_q, pel_d;
  logic                accept;

  // Next-state, pipeline advance and pellet counting.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ram_req    = 1'b0;
    busy       = 1'b0;
    sweep_done = 1'b0;
    accept     = (state_q == S_SCAN) && ram_grant;

    s1_valid_d = accept;
    s1_addr_d  = addr_q;
    tv_d       = s1_valid_q;
    raddr_d    = s1_valid_q ? s1_addr_q : '0;
    rdata_d    = s1_valid_q ? ram_rdata : '0;
    pel_d      = pel_q + ((tv_q && (rdata_q == PELLET)) ? ADDR_W'(1) : ADDR_W'(0));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          addr_d  = '0;
          pel_d   = '0;
        end
      end
      S_SCAN: begin
        ram_req = 1'b1;
        busy    = 1'b1;
        if (ram_grant) begin
          if (addr_q == LAST_ADDR) state_d = S_DRAIN;
          else                     addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave once the final tile's pair is on the outputs.
        if (tv_q && (raddr_q == LAST_ADDR)) state_d = S_DONE;
      end
      S_DONE: begin
        sweep_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers; reset also discards in-flight RAM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      tv_q       <= 1'b0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      pel_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      tv_q       <= tv_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      pel_q      <= pel_d;
    end
  end

  assign ram_addr     = (state_q == S_SCAN) ? addr_q : '0;
  assign read_addr    = raddr_q;
  assign read_data    = rdata_q;
  assign tile_valid   = tv_q;
  assign pellet_count = pel_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_tile_scanner.sv
// Bench for tile_scanner: a RAM model, driver tasks and a scoreboard monitor
// that pops the expected (addr, code) pairs and pellet totals.
module tb_tile_scanner;

  localparam int NUM_TILES = 768;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 4;
  localparam int PW        = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              ram_req;
  logic              ram_grant;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              tile_valid;
  logic              busy;
  logic              sweep_done;
  logic [ADDR_W-1:0] pellet_count;
  logic [1:0]        state_dbg;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int map_mode = 0;
  int tv_cycle[NUM_TILES];

  logic [PW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] exp_pel_q[$];

  tile_scanner #(
    .NUM_TILES(NUM_TILES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PELLET_CODE(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ram_req(ram_req), .ram_grant(ram_grant), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .read_addr(read_addr), .read_data(read_data),
    .tile_valid(tile_valid), .busy(busy), .sweep_done(sweep_done),
    .pellet_count(pellet_count), .state_dbg(state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Map contents: 0 = one pellet at 765, 1 = all pellets, 2 = no pellets.
  function automatic logic [DATA_W-1:0] tile_code(input int a);
    case (map_mode)
      0: return (a == 765) ? 4'd2 : 4'd0;
      1: return 4'd2;
      default: return ((a % 4) == 2) ? 4'd3 : DATA_W'(a % 4);
    endcase
  endfunction

  // RAM model: data for an accepted address appears the next cycle;
  // otherwise garbage.
  always @(posedge clk) begin
    if (ram_req && ram_grant) ram_rdata <= tile_code(int'(ram_addr));
    else                      ram_rdata <= DATA_W'($urandom_range(15, 0));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (tile_valid) begin
        if (exp_q.size() == 0) begin
          check("stray_tile_valid", 32'(tile_valid), 32'd0);
        end else begin
          check("tile_pair", {read_addr, read_data}, exp_q.pop_front());
          tv_cycle[int'(read_addr)] = cyc;
        end
      end else begin
        check("idle_pair_zero", {read_addr, read_data}, 32'd0);
      end
      if (sweep_done) begin
        done_count++;
        check("done_after_last", 32'(cyc - tv_cycle[NUM_TILES-1]), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
        if (exp_pel_q.size() == 0) check("unexpected_done", 32'(sweep_done), 32'd0);
        else                       check("pellet_count", 32'(pellet_count), 32'(exp_pel_q.pop_front()));
      end
    end
  end

  // Queue one sweep's expectations and pulse start; returns start-to-tile latency.
  task automatic run_sweep(input int pel, output int lat);
    for (int a = 0; a < NUM_TILES; a++) exp_q.push_back({ADDR_W'(a), tile_code(a)});
    exp_pel_q.push_back(ADDR_W'(pel));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 1;
    while (!tile_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!sweep_done && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!sweep_done) check("sweep_done_timeout", 32'(sweep_done), 32'd1);
  endtask

  task automatic wait_accept(input int a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ram_req && ram_grant && int'(ram_addr) == a) && n < 5000);
    if (n >= 5000) check("accept_timeout", 32'(ram_addr), 32'(a));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_req"},    32'(ram_req), 32'd0);
    check({tag, "_ram_addr"},   32'(ram_addr), 32'd0);
    check({tag, "_read_addr"},  32'(read_addr), 32'd0);
    check({tag, "_read_data"},  32'(read_data), 32'd0);
    check({tag, "_tile_valid"}, 32'(tile_valid), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
    check({tag, "_pellets"},    32'(pellet_count), 32'd0);
    check({tag, "_state"},      32'(state_dbg), 32'd0);
  endtask

  // Stimulus.
  initial begin
    int lat;
    int d0;
    reset = 1'b1; start = 1'b0; ram_grant = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full-grant sweep, one pellet at 765.
    map_mode = 0;
    run_sweep(1, lat);
    check("first_tile_latency", 32'(lat), 32'd3);
    wait_done();
    repeat (3) @(posedge clk);
    #1;

    // Five-cycle stall after address 100.
    run_sweep(1, lat);
    wait_accept(100);
    @(posedge clk); #1;
    ram_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_addr_hold", 32'(ram_addr), 32'd101);
      check("stall_ram_req", 32'(ram_req), 32'd1);
    end
    @(posedge clk); #1;
    ram_grant = 1'b1;
    wait_done();
    check("tile_gap_99_100", 32'(tv_cycle[100] - tv_cycle[99]), 32'd1);
    check("tile_gap_100_101", 32'(tv_cycle[101] - tv_cycle[100]), 32'd6);
    repeat (3) @(posedge clk);
    #1;

    // Start mid-sweep and in the DONE cycle is ignored.
    map_mode = 2;
    d0 = done_count;
    run_sweep(0, lat);
    repeat (200) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("single_done", 32'(done_count - d0), 32'd1);
    check("no_restart_busy", 32'(busy), 32'd0);

    // Reset mid-sweep at address 400 on an all-pellet map.
    map_mode = 1;
    d0 = done_count;
    run_sweep(NUM_TILES, lat);
    wait_accept(400);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    exp_q.delete();
    exp_pel_q.delete();
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_reset", 32'(done_count - d0), 32'd0);

    // All-pellet sweep from 0, then held through idle.
    run_sweep(NUM_TILES, lat);
    check("restart_latency", 32'(lat), 32'd3);
    wait_done();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("pellet_hold", 32'(pellet_count), 32'd768);
    end

    // Empty map.
    map_mode = 2;
    run_sweep(0, lat);
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    check("final_pellets", 32'(pellet_count), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_pel_drained", 32'(exp_pel_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
